// File: rtl/tpm_port_scheduler.sv
// Shares one single-ported synchronous RAM between three request ports using
// one-entry holding registers, a round-robin arbiter and a tagged read-return pipeline.
module tpm_port_scheduler #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          req_valid_i,
    output logic [2:0]          req_ready_o,
    input  logic [2:0]          req_we_i,
    input  logic [3*ADDR_W-1:0] req_addr_i,
    input  logic [3*WIDTH-1:0]  req_wdata_i,
    input  logic [5:0]          req_tag_i,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [WIDTH-1:0]    mem_wdata_o,
    input  logic [WIDTH-1:0]    mem_rdata_i,
    output logic [2:0]          rsp_valid_o,
    output logic [3*WIDTH-1:0]  rsp_data_o,
    output logic [5:0]          rsp_tag_o,
    output logic                busy_o
);

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} entry_state_e;

    entry_state_e      state_q [3];
    entry_state_e      state_d [3];
    logic [2:0]        we_q;
    logic [ADDR_W-1:0] addr_q  [3];
    logic [WIDTH-1:0]  wdata_q [3];
    logic [1:0]        tag_q   [3];
    logic [1:0]        last_q;

    logic [2:0] pending;
    logic [2:0] grant;
    logic [2:0] accept;
    logic [1:0] grant_id;
    logic [1:0] sel;
    logic       any_grant;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WIDTH-1:0]  mem_wdata_q;

    // Stage 0 travels alongside mem_en; stage RD_LAT lines up with mem_rdata.
    logic [RD_LAT:0] pv_q;
    logic [1:0]      pid_q  [RD_LAT+1];
    logic [1:0]      ptag_q [RD_LAT+1];

    logic [2:0]         rsp_valid_q;
    logic [3*WIDTH-1:0] rsp_data_q;
    logic [5:0]         rsp_tag_q;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("tpm_port_scheduler: RD_LAT=%0d outside legal range 1..4", RD_LAT);
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            pending[i] = (state_q[i] == PENDING);
        end
    end

    // Round-robin: search starts at the port after last_q and wraps 3 -> 1.
    always_comb begin
        grant = 3'b000;
        case (last_q)
            2'd1: begin
                if (pending[1])      grant = 3'b010;
                else if (pending[2]) grant = 3'b100;
                else if (pending[0]) grant = 3'b001;
            end
            2'd2: begin
                if (pending[2])      grant = 3'b100;
                else if (pending[0]) grant = 3'b001;
                else if (pending[1]) grant = 3'b010;
            end
            default: begin
                if (pending[0])      grant = 3'b001;
                else if (pending[1]) grant = 3'b010;
                else if (pending[2]) grant = 3'b100;
            end
        endcase
    end

    always_comb begin
        grant_id = 2'd0;
        sel      = 2'd0;
        case (grant)
            3'b001: begin grant_id = 2'd1; sel = 2'd0; end
            3'b010: begin grant_id = 2'd2; sel = 2'd1; end
            3'b100: begin grant_id = 2'd3; sel = 2'd2; end
            default: ;
        endcase
    end

    assign any_grant   = |grant;
    assign req_ready_o = ~pending | grant;
    assign accept      = req_valid_i & req_ready_o;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (accept[i]) state_d[i] = PENDING;
                PENDING: if (grant[i] && !accept[i]) state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= IDLE;
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            we_q   <= '0;
            last_q <= 2'd3;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                if (accept[i]) begin
                    we_q[i]    <= req_we_i[i];
                    addr_q[i]  <= req_addr_i[i*ADDR_W +: ADDR_W];
                    wdata_q[i] <= req_wdata_i[i*WIDTH +: WIDTH];
                    tag_q[i]   <= req_tag_i[i*2 +: 2];
                end
            end
            if (any_grant) last_q <= grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= any_grant;
            mem_we_q <= any_grant & we_q[sel];
            if (any_grant) begin
                mem_addr_q  <= addr_q[sel];
                mem_wdata_q <= wdata_q[sel];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                pid_q[i]  <= '0;
                ptag_q[i] <= '0;
            end
        end else begin
            pv_q      <= {pv_q[RD_LAT-1:0], any_grant & ~we_q[sel]};
            pid_q[0]  <= grant_id;
            ptag_q[0] <= tag_q[sel];
            for (int i = 1; i <= RD_LAT; i++) begin
                pid_q[i]  <= pid_q[i-1];
                ptag_q[i] <= ptag_q[i-1];
            end
        end
    end

    // Only the addressed port's data/tag slice is updated; the others hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
        end else begin
            rsp_valid_q <= 3'b000;
            if (pv_q[RD_LAT]) begin
                for (int p = 0; p < 3; p++) begin
                    if (pid_q[RD_LAT] == 2'(p + 1)) begin
                        rsp_valid_q[p]               <= 1'b1;
                        rsp_data_q[p*WIDTH +: WIDTH] <= mem_rdata_i;
                        rsp_tag_q[p*2 +: 2]          <= ptag_q[RD_LAT];
                    end
                end
            end
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_tag_o   = rsp_tag_q;
    assign busy_o      = (|pending) | (|pv_q) | (|rsp_valid_q);

endmodule
